// File: rtl/wb_dbg_arbiter.sv
// Two-master round-robin arbiter that shares the debug/status slave port between two
// requesters. It serialises accesses, returns each response to its owner and aborts
// accesses the slave never answers.
module wb_dbg_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        PHY_CLK33_I,
    input  logic        PHY_RSTn_I,
    input  logic [31:0] M0_ADD_I,
    input  logic [31:0] M0_DATA_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    output logic [31:0] M0_DATA_O,
    output logic        M0_ACK_O,
    output logic        M0_VALID_O,
    output logic        M0_ERR_O,
    input  logic [31:0] M1_ADD_I,
    input  logic [31:0] M1_DATA_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    output logic [31:0] M1_DATA_O,
    output logic        M1_ACK_O,
    output logic        M1_VALID_O,
    output logic        M1_ERR_O,
    output logic [31:0] S_ADD_O,
    output logic [31:0] S_DATA_O,
    output logic        S_STB_O,
    output logic        S_WE_O,
    input  logic [31:0] S_DATA_I,
    input  logic        S_ACK_I,
    input  logic        S_VALID_I,
    output logic [1:0]  GNT_O,
    output logic [15:0] TIMEOUT_CNT_O
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [7:0] TIMER_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  timer_q, timer_d;
    logic [31:0] s_add_q, s_add_d;
    logic [31:0] s_data_q, s_data_d;
    logic        s_stb_q, s_stb_d;
    logic        s_we_q, s_we_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  valid_q, valid_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] m0_data_q, m0_data_d;
    logic [31:0] m1_data_q, m1_data_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    logic        owner_stb;
    logic        win;

    assign owner_stb = owner_q ? M1_STB_I : M0_STB_I;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        timer_d   = timer_q;
        s_add_d   = s_add_q;
        s_data_d  = s_data_q;
        s_stb_d   = s_stb_q;
        s_we_d    = s_we_q;
        gnt_d     = gnt_q;
        ack_d     = ack_q;
        valid_d   = valid_q;
        err_d     = err_q;
        m0_data_d = m0_data_q;
        m1_data_d = m1_data_q;
        tmo_cnt_d = tmo_cnt_q;
        win       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A stale slave response must drain before the next access starts.
                if (!S_ACK_I && !S_VALID_I && (M0_STB_I || M1_STB_I)) begin
                    win      = (M0_STB_I && M1_STB_I) ? ~last_q : M1_STB_I;
                    owner_d  = win;
                    s_add_d  = win ? M1_ADD_I  : M0_ADD_I;
                    s_data_d = win ? M1_DATA_I : M0_DATA_I;
                    s_we_d   = win ? M1_WE_I   : M0_WE_I;
                    s_stb_d  = 1'b1;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    timer_d  = 8'd0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!owner_stb) begin
                    s_stb_d = 1'b0;
                    state_d = ST_RELEASE;
                end else if (s_we_q && S_ACK_I) begin
                    ack_d[owner_q] = 1'b1;
                    s_stb_d        = 1'b0;
                    state_d        = ST_RELEASE;
                end else if (!s_we_q && S_VALID_I) begin
                    valid_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        m1_data_d = S_DATA_I;
                    end else begin
                        m0_data_d = S_DATA_I;
                    end
                    s_stb_d = 1'b0;
                    state_d = ST_RELEASE;
                end else if (timer_q == TIMER_LIMIT) begin
                    err_d[owner_q] = 1'b1;
                    s_stb_d        = 1'b0;
                    if (tmo_cnt_q != 16'hFFFF) begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                    state_d = ST_RELEASE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (!owner_stb) begin
                    ack_d[owner_q]   = 1'b0;
                    valid_d[owner_q] = 1'b0;
                    err_d[owner_q]   = 1'b0;
                    if (owner_q) begin
                        m1_data_d = 32'h0;
                    end else begin
                        m0_data_d = 32'h0;
                    end
                    gnt_d   = 2'b00;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            timer_q   <= 8'd0;
            s_add_q   <= 32'h0;
            s_data_q  <= 32'h0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            gnt_q     <= 2'b00;
            ack_q     <= 2'b00;
            valid_q   <= 2'b00;
            err_q     <= 2'b00;
            m0_data_q <= 32'h0;
            m1_data_q <= 32'h0;
            tmo_cnt_q <= 16'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            s_add_q   <= s_add_d;
            s_data_q  <= s_data_d;
            s_stb_q   <= s_stb_d;
            s_we_q    <= s_we_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            m0_data_q <= m0_data_d;
            m1_data_q <= m1_data_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign M0_DATA_O     = m0_data_q;
    assign M0_ACK_O      = ack_q[0];
    assign M0_VALID_O    = valid_q[0];
    assign M0_ERR_O      = err_q[0];
    assign M1_DATA_O     = m1_data_q;
    assign M1_ACK_O      = ack_q[1];
    assign M1_VALID_O    = valid_q[1];
    assign M1_ERR_O      = err_q[1];
    assign S_ADD_O       = s_add_q;
    assign S_DATA_O      = s_data_q;
    assign S_STB_O       = s_stb_q;
    assign S_WE_O        = s_we_q;
    assign GNT_O         = gnt_q;
    assign TIMEOUT_CNT_O = tmo_cnt_q;

endmodule

// File: tb/tb_wb_dbg_arbiter.sv
// Bench for wb_dbg_arbiter: a registered slave model answers accesses after a programmable
// delay, and a grant scoreboard follows every slave access the arbiter starts.
module tb_wb_dbg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m0Add = '0, m0Data = '0, m1Add = '0, m1Data = '0;
    logic        m0Stb = 1'b0, m0We = 1'b0, m1Stb = 1'b0, m1We = 1'b0;
    logic [31:0] M0_DATA_O, M1_DATA_O, S_ADD_O, S_DATA_O;
    logic        M0_ACK_O, M0_VALID_O, M0_ERR_O, M1_ACK_O, M1_VALID_O, M1_ERR_O;
    logic        S_STB_O, S_WE_O;
    logic [1:0]  GNT_O;
    logic [15:0] TIMEOUT_CNT_O;
    logic [31:0] sRdata;
    logic        sAck, sValid;

    int          errors = 0;
    int          checks = 0;
    int          slaveDelay = 1;
    int          slaveCnt;
    logic [31:0] slaveRdata = 32'h0;

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    grant_t expQ[$];
    grant_t curExp;
    logic   prevStb = 1'b0;
    int     highLen = 0;
    int     lastHighLen = 0;

    wb_dbg_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .PHY_CLK33_I  (clk),
        .PHY_RSTn_I   (rst_n),
        .M0_ADD_I     (m0Add),
        .M0_DATA_I    (m0Data),
        .M0_STB_I     (m0Stb),
        .M0_WE_I      (m0We),
        .M0_DATA_O    (M0_DATA_O),
        .M0_ACK_O     (M0_ACK_O),
        .M0_VALID_O   (M0_VALID_O),
        .M0_ERR_O     (M0_ERR_O),
        .M1_ADD_I     (m1Add),
        .M1_DATA_I    (m1Data),
        .M1_STB_I     (m1Stb),
        .M1_WE_I      (m1We),
        .M1_DATA_O    (M1_DATA_O),
        .M1_ACK_O     (M1_ACK_O),
        .M1_VALID_O   (M1_VALID_O),
        .M1_ERR_O     (M1_ERR_O),
        .S_ADD_O      (S_ADD_O),
        .S_DATA_O     (S_DATA_O),
        .S_STB_O      (S_STB_O),
        .S_WE_O       (S_WE_O),
        .S_DATA_I     (sRdata),
        .S_ACK_I      (sAck),
        .S_VALID_I    (sValid),
        .GNT_O        (GNT_O),
        .TIMEOUT_CNT_O(TIMEOUT_CNT_O)
    );

    always #5 clk = ~clk;

    // Registered slave: answers once S_STB_O has been sampled high slaveDelay times, 0 = never.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slaveCnt <= 0;
            sAck     <= 1'b0;
            sValid   <= 1'b0;
            sRdata   <= 32'h0;
        end else begin
            slaveCnt <= S_STB_O ? slaveCnt + 1 : 0;
            if (S_STB_O && slaveDelay != 0 && slaveCnt + 1 >= slaveDelay) begin
                sAck   <= S_WE_O;
                sValid <= !S_WE_O;
                sRdata <= S_WE_O ? 32'h0 : slaveRdata;
            end else begin
                sAck   <= 1'b0;
                sValid <= 1'b0;
                sRdata <= 32'h0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every rising S_STB_O is a new slave access and must match the next expected grant.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStb = 1'b0;
            highLen = 0;
        end else begin
            if (S_STB_O && !prevStb) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_grant", 64'(GNT_O), 64'h0);
                end else begin
                    curExp = expQ.pop_front();
                    checkOutput("grant_gnt", 64'(GNT_O), 64'(curExp.gnt));
                    checkOutput("grant_bus", {S_WE_O, S_ADD_O}, {curExp.we, curExp.addr});
                    checkOutput("grant_wdata", 64'(S_DATA_O), 64'(curExp.wdata));
                end
                highLen = 1;
            end else if (S_STB_O) begin
                highLen++;
            end else if (prevStb) begin
                lastHighLen = highLen;
            end
            prevStb = S_STB_O;
        end
    end

    task automatic expectGrant(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        grant_t g;
        g.gnt   = (m == 0) ? 2'b01 : 2'b10;
        g.we    = we;
        g.addr  = addr;
        g.wdata = wdata;
        expQ.push_back(g);
    endtask

    task automatic driveMaster(input int m, input logic stb, input logic we, input logic [31:0] addr, input logic [31:0] data);
        if (m == 0) begin
            m0Stb = stb; m0We = we; m0Add = addr; m0Data = data;
        end else begin
            m1Stb = stb; m1We = we; m1Add = addr; m1Data = data;
        end
    endtask

    function automatic logic [34:0] respOf(input int m);
        return (m == 0) ? {M0_ACK_O, M0_VALID_O, M0_ERR_O, M0_DATA_O}
                        : {M1_ACK_O, M1_VALID_O, M1_ERR_O, M1_DATA_O};
    endfunction

    // One complete master transaction: request, wait for the response, check it, release.
    task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr, input int expCyc, input logic corrupt);
        int          cyc;
        logic [34:0] r;
        logic [34:0] exp;
        @(negedge clk);
        driveMaster(m, 1'b1, we, addr, wdata);
        cyc = 0;
        r   = '0;
        while (r[34:32] == 3'b000 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (corrupt && cyc == 1) driveMaster(m, 1'b1, !we, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
            r = respOf(m);
        end
        if (r[34:32] == 3'b000) begin
            checkOutput($sformatf("m%0d_no_response", m), 64'h0, 64'h1);
        end else begin
            exp = {we && !expErr, !we && !expErr, expErr, (!we && !expErr) ? expRdata : 32'h0};
            checkOutput($sformatf("m%0d_response", m), 64'(r), 64'(exp));
            if (expCyc != 0) checkOutput($sformatf("m%0d_latency", m), 64'(cyc), 64'(expCyc));
            checkOutput($sformatf("m%0d_other_quiet", m), 64'(respOf(1 - m)), 64'h0);
            if (we && !expErr) checkOutput("slave_write_latch", {S_WE_O, S_DATA_O}, {1'b1, wdata});
        end
        driveMaster(m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput($sformatf("m%0d_cleared", m), 64'(respOf(m)), 64'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", {GNT_O, S_STB_O, S_WE_O, M0_ACK_O, M0_VALID_O, M0_ERR_O,
                                   M1_ACK_O, M1_VALID_O, M1_ERR_O, TIMEOUT_CNT_O}, 64'h0);
        checkOutput("reset_slave_bus", {S_ADD_O, S_DATA_O}, 64'h0);
        checkOutput("reset_master_data", {M0_DATA_O, M1_DATA_O}, 64'h0);
        rst_n = 1'b1;

        // Single read with a one-cycle slave.
        slaveDelay = 1;
        slaveRdata = 32'hAAAA_5555;
        expectGrant(0, 1'b0, 32'h0000_0004, 32'h0);
        applyStimulus(0, 1'b0, 32'h0000_0004, 32'h0, 32'hAAAA_5555, 1'b0, 3, 1'b0);

        // Write whose request lines change while the access is in flight.
        expectGrant(1, 1'b1, 32'h0000_0000, 32'h0000_0003);
        applyStimulus(1, 1'b1, 32'h0000_0000, 32'h0000_0003, 32'h0, 1'b0, 3, 1'b1);

        // Slave never answers.
        slaveDelay = 0;
        expectGrant(0, 1'b0, 32'h0000_0010, 32'h0);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 5, 1'b0);
        checkOutput("timeout_stb_len", 64'(lastHighLen), 64'd4);
        checkOutput("timeout_cnt", 64'(TIMEOUT_CNT_O), 64'd1);

        // Response lands on the limit cycle: completion, not a timeout.
        slaveDelay = 3;
        expectGrant(1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        applyStimulus(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0, 5, 1'b0);
        checkOutput("limit_cnt_unchanged", 64'(TIMEOUT_CNT_O), 64'd1);

        // Master gives up mid-access.
        slaveDelay = 0;
        expectGrant(0, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        driveMaster(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        repeat (2) @(negedge clk);
        driveMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_no_response", 64'(respOf(0)), 64'h0);
        end
        checkOutput("abort_idle", {GNT_O, S_STB_O}, 64'h0);
        checkOutput("abort_cnt_unchanged", 64'(TIMEOUT_CNT_O), 64'd1);

        // Reset lands in the middle of an access.
        expectGrant(0, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk);
        driveMaster(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", {GNT_O, S_STB_O, M0_ACK_O, M0_VALID_O, M0_ERR_O, TIMEOUT_CNT_O}, 64'h0);
        checkOutput("async_reset_bus", {S_ADD_O, S_DATA_O}, 64'h0);
        driveMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contested rounds: M0 wins first after reset, then grants must alternate.
        slaveDelay = 1;
        for (int r = 0; r < 4; r++) begin
            logic [31:0] a0, a1, d1;
            a0 = 32'h0000_0100 + 32'(r) * 32'd4;
            a1 = 32'h0000_0200 + 32'(r) * 32'd4;
            d1 = 32'h5A00_0000 + 32'(r);
            slaveRdata = 32'hC0DE_0000 + 32'(r);
            expectGrant(0, 1'b0, a0, 32'h0);
            expectGrant(1, 1'b1, a1, d1);
            fork
                applyStimulus(0, 1'b0, a0, 32'h0, 32'hC0DE_0000 + 32'(r), 1'b0, 0, 1'b0);
                applyStimulus(1, 1'b1, a1, d1, 32'h0, 1'b0, 0, 1'b0);
            join
        end

        repeat (3) @(negedge clk);
        checkOutput("grant_queue_drained", 64'(expQ.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_dbg_arbiter.md
# wb_dbg_arbiter

Two-master Wishbone arbiter that shares one debug/status slave port between two requesters, for example the PCI target path and a local debug master. It uses the codebase's single-word handshake: the slave raises ACK for writes and VALID for reads, and holds it while STB is high. The arbiter serialises transactions with round-robin fairness, forwards each access to the slave, returns the response to its owner, and aborts with an error if the slave does not answer.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of cycles S_STB_O stays high for one access before the access is aborted; legal range 2..255.
- PHY_CLK33_I  in  1  single clock, 33 MHz.
- PHY_RSTn_I  in  1  reset, asynchronous, active-low.
- M0_ADD_I, M1_ADD_I  in  32  master byte address.
- M0_DATA_I, M1_DATA_I  in  32  master write data.
- M0_STB_I, M1_STB_I  in  1  master request; held high until the response is seen.
- M0_WE_I, M1_WE_I  in  1  1 = write, 0 = read.
- M0_DATA_O, M1_DATA_O  out  32  read data returned to the master.
- M0_ACK_O, M1_ACK_O  out  1  write complete.
- M0_VALID_O, M1_VALID_O  out  1  read data valid.
- M0_ERR_O, M1_ERR_O  out  1  access timed out.
- S_ADD_O  out  32  slave address.
- S_DATA_O  out  32  slave write data.
- S_STB_O  out  1  slave request.
- S_WE_O  out  1  slave write enable.
- S_DATA_I  in  32  slave read data.
- S_ACK_I  in  1  slave write acknowledge.
- S_VALID_I  in  1  slave read valid.
- GNT_O  out  2  one-hot current owner; 0 when idle.
- TIMEOUT_CNT_O  out  16  saturating count of timed-out accesses.

## Operation
- Reset state: every output is 0; `last` = 1, so M0 wins the first contest; FSM is in IDLE; timer = 0.
- FSM states are IDLE, BUSY and RELEASE; all outputs are registered.
- IDLE:
  - Granting requires that S_ACK_I and S_VALID_I are both 0.
  - If exactly one STB is high, that master wins.
  - If both are high, the master other than `last` wins.
  - On grant: latch the winner's ADD, DATA and WE into S_ADD_O, S_DATA_O and S_WE_O; set S_STB_O = 1; set the GNT_O bit; clear the timer; go to BUSY.
- BUSY:
  - Changes on the owner's ADD, DATA or WE are ignored.
  - Write completes when S_WE_O = 1 and S_ACK_I = 1: set owner ACK_O = 1.
  - Read completes when S_WE_O = 0 and S_VALID_I = 1: set owner VALID_O = 1 and owner DATA_O = S_DATA_I.
  - On either completion: S_STB_O = 0, go to RELEASE.
  - A response of the wrong type (for example ACK during a read) is ignored.
  - Otherwise the timer increments. When timer = TIMEOUT_CYCLES-1 and no response has arrived: S_STB_O = 0, owner ERR_O = 1, TIMEOUT_CNT_O increments (saturating at 0xFFFF), go to RELEASE.
  - A response and the timeout limit in the same cycle count as a completion, not a timeout.
  - Abort: if the owner drops STB in BUSY, set S_STB_O = 0 and go to RELEASE with no response to the master.
- RELEASE:
  - Owner responses are held.
  - Exit to IDLE when the owner's STB = 0. On that edge: clear the owner's ACK_O, VALID_O, ERR_O and DATA_O; clear GNT_O; set `last` = owner.
- The non-owner master sees ACK_O, VALID_O, ERR_O and DATA_O all 0 while it waits.
- Asynchronous reset in any state returns immediately to the reset state. An in-flight access is dropped and TIMEOUT_CNT_O is cleared.

## Timing
- Grant latency: with STB sampled high in IDLE at edge N, S_STB_O = 1 after edge N.
- Response latency: the master response is asserted at the edge after the one that samples S_ACK_I or S_VALID_I high.
- With the debug slave (one-cycle response): M_STB high at edge N, slave responds at N+1, master ACK_O/VALID_O at N+2.
- Back-to-back: after the owner drops STB, the next grant comes no earlier than 1 cycle later, and only once the slave's responses are low. The slave never sees two accesses without an intervening S_STB_O = 0 cycle.
- On timeout, S_STB_O is high for exactly TIMEOUT_CYCLES cycles.

## Test plan
- Single read: M0 reads 0x004 while the slave returns 0xAAAA5555 one cycle after STB → M0_VALID_O = 1 and M0_DATA_O = 0xAAAA5555 exactly 2 edges after S_STB_O rises; M1 outputs stay 0; GNT_O = 01.
- Simultaneous requests: M0 and M1 raise STB on the same cycle and each drops STB once served, repeated 4 times → grants strictly alternate M0, M1, M0, M1; at least one S_STB_O-low cycle between accesses.
- Write latch: M1 writes 0x00000003 to 0x000, then changes DATA_I to 0xFFFFFFFF mid-BUSY → slave receives S_DATA_O = 0x00000003 and S_WE_O = 1; M1_ACK_O rises.
- Timeout: TIMEOUT_CYCLES = 4, slave never responds → S_STB_O high for 4 cycles, then M0_ERR_O = 1 and TIMEOUT_CNT_O = 1; ERR_O clears when M0 drops STB.
- Edge cases: the slave responds on the limit cycle → completion, TIMEOUT_CNT_O unchanged. The master drops STB in BUSY → no response, FSM back in IDLE. Reset asserted mid-BUSY → all outputs 0 asynchronously.
